// File: rtl/mul_axi_pkg.sv
// Shared types for the multiplier request initiator: FSM states and operand pair layout.
// Pure declarations, no logic.
package mul_axi_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RES
  } req_state_t;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] A;
    logic [WIDTH_DEF-1:0] B;
  } op_pair_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead read and full/empty flags; 1-cycle write-to-read.
// Push while full is dropped even when a pop occurs the same cycle; pop while empty is ignored.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mul_req_initiator.sv
// Issues queued operand pairs to the multiplier one at a time and buffers products in order.
// Push to src_valid takes 2 cycles; result back-pressure holds dst_ready low; stalled responses time out.
module mul_req_initiator
  import mul_axi_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_push,
  input  logic [WIDTH-1:0]   op_A,
  input  logic [WIDTH-1:0]   op_B,
  output logic               op_full,
  output logic               src_valid,
  input  logic               src_ready,
  output logic [WIDTH-1:0]   src_A,
  output logic [WIDTH-1:0]   src_B,
  input  logic               dst_valid,
  output logic               dst_ready,
  input  logic [2*WIDTH-1:0] dst_P,
  output logic               res_valid,
  input  logic               res_pop,
  output logic [2*WIDTH-1:0] res_P,
  output logic [7:0]         done_cnt,
  output logic               err_timeout,
  input  logic               err_clr
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  req_state_t         state;
  req_state_t         state_nxt;
  logic [2*WIDTH-1:0] op_dout;
  logic               op_empty;
  logic               op_pop;
  logic               res_full;
  logic               res_empty;
  logic               res_push;
  logic [TW-1:0]      tmo_cnt;
  logic               drain;
  logic               src_hs;
  logic               dst_hs;
  logic               accept;
  logic               discard;
  logic               timeout;

  sync_fifo #(.W(2*WIDTH), .DEPTH(DEPTH)) u_op_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (op_push),
    .din   ({op_A, op_B}),
    .pop   (op_pop),
    .dout  (op_dout),
    .full  (op_full),
    .empty (op_empty)
  );

  sync_fifo #(.W(2*WIDTH), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (res_push),
    .din   (dst_P),
    .pop   (res_pop),
    .dout  (res_P),
    .full  (res_full),
    .empty (res_empty)
  );

  assign res_valid = !res_empty;
  assign src_valid = (state == ISSUE);
  // A pending stale product must always be absorbable, so drain forces dst_ready.
  assign dst_ready = (state == WAIT_RES) ? (!res_full || drain) : drain;
  assign src_hs    = src_valid && src_ready;
  assign dst_hs    = dst_valid && dst_ready;
  assign discard   = dst_hs && drain;
  assign accept    = dst_hs && !drain && (state == WAIT_RES);
  assign res_push  = accept;
  assign timeout   = (state == WAIT_RES) && !accept && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    op_pop    = 1'b0;
    case (state)
      IDLE: begin
        if (!op_empty) begin
          op_pop    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (src_hs) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (accept) begin
          if (!op_empty) begin
            op_pop    = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      src_A       <= '0;
      src_B       <= '0;
      tmo_cnt     <= '0;
      drain       <= 1'b0;
      done_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (op_pop) begin
        src_A <= op_dout[2*WIDTH-1:WIDTH];
        src_B <= op_dout[WIDTH-1:0];
      end
      if (src_hs)                 tmo_cnt <= '0;
      else if (state == WAIT_RES) tmo_cnt <= tmo_cnt + TW'(1);
      // A fresh timeout re-arms drain even if an older stale product is discarded now.
      if (timeout)      drain <= 1'b1;
      else if (discard) drain <= 1'b0;
      if (accept) done_cnt <= done_cnt + 8'd1;
      if (timeout)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_req_initiator.sv
// Directed bench for mul_req_initiator with a behavioural multiplier responder.
module tb_mul_req_initiator;

  localparam int WIDTH = 16;

  logic               clk;
  logic               reset;
  logic               op_push;
  logic [WIDTH-1:0]   op_A;
  logic [WIDTH-1:0]   op_B;
  logic               op_full;
  logic               src_valid;
  logic               src_ready;
  logic [WIDTH-1:0]   src_A;
  logic [WIDTH-1:0]   src_B;
  logic               dst_valid;
  logic               dst_ready;
  logic [2*WIDTH-1:0] dst_P;
  logic               res_valid;
  logic               res_pop;
  logic [2*WIDTH-1:0] res_P;
  logic [7:0]         done_cnt;
  logic               err_timeout;
  logic               err_clr;

  // Responder knobs
  bit src_block;
  int src_stall;
  int lat;
  bit respond;
  bit late_go;

  int passed;
  int failed;
  int total;

  mul_req_initiator #(.WIDTH(WIDTH), .DEPTH(4), .TIMEOUT(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .op_push     (op_push),
    .op_A        (op_A),
    .op_B        (op_B),
    .op_full     (op_full),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_A       (src_A),
    .src_B       (src_B),
    .dst_valid   (dst_valid),
    .dst_ready   (dst_ready),
    .dst_P       (dst_P),
    .res_valid   (res_valid),
    .res_pop     (res_pop),
    .res_P       (res_P),
    .done_cnt    (done_cnt),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Multiplier model: accepts a pair after src_stall cycles, answers after lat cycles.
  initial begin : model
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    bit was;
    src_ready = 1'b0;
    dst_valid = 1'b0;
    dst_P     = '0;
    forever begin
      @(posedge clk); #1;
      if (reset && src_valid && !src_block) begin
        repeat (src_stall) begin @(posedge clk); #1; end
        src_ready = 1'b1;
        a = src_A;
        b = src_B;
        @(posedge clk); #1;
        src_ready = 1'b0;
        if (!respond) begin
          while (!late_go) begin @(posedge clk); #1; end
          dst_P = 32'd42;
        end else begin
          repeat (lat) begin @(posedge clk); #1; end
          dst_P = 32'(a) * 32'(b);
        end
        dst_valid = 1'b1;
        was = 1'b0;
        while (!was) begin
          was = dst_ready;
          @(posedge clk); #1;
        end
        dst_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op_A = a;
    op_B = b;
    op_push = 1'b1;
    step(1);
    op_push = 1'b0;
  endtask

  task automatic pop();
    res_pop = 1'b1;
    step(1);
    res_pop = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int i = 0;
    while (!res_valid && i < 300) begin step(1); i++; end
    chk(tag, 64'(res_valid), 64'd1);
  endtask

  task automatic wait_done(input logic [7:0] n, input string tag);
    int i = 0;
    while (done_cnt != n && i < 300) begin step(1); i++; end
    chk(tag, 64'(done_cnt), 64'(n));
  endtask

  initial begin : stim
    int cnt;
    logic [31:0] exp_p [4];
    passed = 0; failed = 0; total = 0;
    reset = 1'b0; op_push = 1'b0; op_A = '0; op_B = '0; res_pop = 1'b0; err_clr = 1'b0;
    src_block = 1'b0; src_stall = 0; lat = 17; respond = 1'b1; late_go = 1'b0;

    // Reset state
    #3;
    chk("rst_src_valid", 64'(src_valid), 64'd0);
    chk("rst_dst_ready", 64'(dst_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_P", 64'(res_P), 64'd0);
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_src_AB", 64'({src_A, src_B}), 64'd0);
    chk("rst_op_full", 64'(op_full), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(2);

    // 1: single request, latency of issue
    push(16'd3, 16'd5);
    chk("t1_valid_early", 64'(src_valid), 64'd0);
    step(1);
    chk("t1_issue", 64'({src_valid, src_A, src_B}), {31'd0, 1'b1, 16'd3, 16'd5});
    wait_res("t1_wait_res");
    chk("t1_res_P", 64'(res_P), 64'd15);
    chk("t1_done", 64'(done_cnt), 64'd1);
    pop();
    chk("t1_res_empty", 64'(res_valid), 64'd0);

    // 2: four requests with src stalls, in-order results
    src_stall = 3; lat = 4;
    exp_p[0] = 32'd6; exp_p[1] = 32'd110; exp_p[2] = 32'd49; exp_p[3] = 32'd510;
    push(16'd2, 16'd3);
    push(16'd10, 16'd11);
    chk("t2_stable_a", 64'({src_valid, src_A, src_B}), {31'd0, 1'b1, 16'd2, 16'd3});
    push(16'd7, 16'd7);
    chk("t2_stable_b", 64'({src_valid, src_A, src_B}), {31'd0, 1'b1, 16'd2, 16'd3});
    push(16'd255, 16'd2);
    chk("t2_stable_c", 64'({src_valid, src_A, src_B}), {31'd0, 1'b1, 16'd2, 16'd3});
    step(1);
    chk("t2_stable_d", 64'({src_valid, src_A, src_B}), {31'd0, 1'b1, 16'd2, 16'd3});
    for (int k = 0; k < 4; k++) begin
      wait_res("t2_wait_res");
      chk("t2_res_P", 64'(res_P), 64'(exp_p[k]));
      pop();
    end
    chk("t2_done", 64'(done_cnt), 64'd5);

    // 3: src_ready held low, queue fills, sixth push dropped
    src_block = 1'b1; src_stall = 0; lat = 2;
    for (int k = 1; k <= 6; k++) push(16'(k), 16'(k));
    chk("t3_op_full", 64'(op_full), 64'd1);
    chk("t3_hold", 64'({src_valid, src_A, src_B}), {31'd0, 1'b1, 16'd1, 16'd1});
    src_block = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      wait_res("t3_wait_res");
      chk("t3_res_P", 64'(res_P), 64'(k * k));
      pop();
    end
    step(40);
    chk("t3_done", 64'(done_cnt), 64'd10);
    chk("t3_no_sixth", 64'(res_valid), 64'd0);

    // 4: result queue back-pressure
    lat = 1;
    for (int k = 11; k <= 15; k++) push(16'(k), 16'd1);
    wait_done(8'd14, "t4_four_done");
    cnt = 0;
    while (!dst_valid && cnt < 50) begin step(1); cnt++; end
    step(2);
    chk("t4_held_valid", 64'(dst_valid), 64'd1);
    chk("t4_dst_ready_low", 64'(dst_ready), 64'd0);
    chk("t4_done_hold", 64'(done_cnt), 64'd14);
    chk("t4_head", 64'(res_P), 64'd11);
    pop();
    chk("t4_dst_ready_high", 64'(dst_ready), 64'd1);
    step(1);
    chk("t4_fifth_done", 64'(done_cnt), 64'd15);
    for (int k = 12; k <= 15; k++) begin
      wait_res("t4_wait_res");
      chk("t4_res_P", 64'(res_P), 64'(k));
      pop();
    end

    // 5: timeout, drain of late product, recovery, err_clr
    respond = 1'b0;
    push(16'd6, 16'd7);
    cnt = 0;
    while (!src_valid && cnt < 20) begin step(1); cnt++; end
    chk("t5_issued", 64'(src_valid), 64'd1);
    cnt = 0;
    while (!err_timeout && cnt < 200) begin step(1); cnt++; end
    chk("t5_tmo_cycles", 64'(cnt), 64'd65);
    chk("t5_drain_ready", 64'(dst_ready), 64'd1);
    late_go = 1'b1;
    step(4);
    late_go = 1'b0;
    respond = 1'b1;
    chk("t5_discarded", 64'(res_valid), 64'd0);
    chk("t5_done_same", 64'(done_cnt), 64'd15);
    chk("t5_drain_clear", 64'(dst_ready), 64'd0);
    push(16'd8, 16'd8);
    wait_res("t5_wait_res");
    chk("t5_res_P", 64'(res_P), 64'd64);
    chk("t5_done", 64'(done_cnt), 64'd16);
    chk("t5_err_sticky", 64'(err_timeout), 64'd1);
    pop();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("t5_err_clr", 64'(err_timeout), 64'd0);

    // 6: asynchronous reset during ISSUE
    src_block = 1'b1;
    push(16'd5, 16'd5);
    push(16'd9, 16'd9);
    chk("t6_in_issue", 64'(src_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_src_valid", 64'(src_valid), 64'd0);
    chk("t6_dst_ready", 64'(dst_ready), 64'd0);
    chk("t6_res_valid", 64'(res_valid), 64'd0);
    chk("t6_done", 64'(done_cnt), 64'd0);
    chk("t6_op_full", 64'(op_full), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    src_block = 1'b0;
    step(1);
    push(16'd7, 16'd9);
    wait_res("t6_wait_res");
    chk("t6_res_P", 64'(res_P), 64'd63);
    pop();
    step(20);
    chk("t6_done_after", 64'(done_cnt), 64'd1);
    chk("t6_flushed", 64'(res_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
